// File: rtl/mult_pipe_hs_wrapper.sv
// Pipelined WIDTHxWIDTH multiplier with valid/ready on both sides, bubble-collapsing slots.
// Optional performance counters (cnt_done, cnt_stall) when MULT_PIPE_PERF_CNT_EN is defined.
module mult_pipe_hs_wrapper #(
    parameter int WIDTH       = 16,
    parameter int SIGNED      = 1,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag
`ifdef MULT_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          cnt_done,
    output logic [31:0]          cnt_stall
`endif
);

    localparam int N  = PIPE_STAGES + 2;
    localparam int PW = 2 * WIDTH;

    // vld_q[0] is S0, vld_q[N-1] is SO; load[k] means slot k takes slot k-1 this cycle.
    logic [N-1:0]       vld_q;
    logic [N-1:0]       load;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [TAG_W-1:0]   tag0_q;
    logic [PW-1:0]      a_ext, b_ext, mul_res;
    logic [PW-1:0]      so_src_prod;
    logic [TAG_W-1:0]   so_src_tag;
    logic [PW-1:0]      so_prod;
    logic [TAG_W-1:0]   so_tag;
    logic               in_fire;

    // NOTE: every signal written in always_comb gets a default before any conditional
    // logic, otherwise synthesis infers a latch to hold the unassigned case.
    always_comb begin
        load = '0;
        load[N-1] = !vld_q[N-1] || out_ready;
        for (int k = N - 2; k >= 0; k--) begin
            load[k] = !vld_q[k] || load[k+1];
        end
    end

    assign in_ready = load[0] && !rst;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        a_ext   = (SIGNED != 0) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = (SIGNED != 0) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        mul_res = a_ext * b_ext;
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking here would let one slot see its neighbour's new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            if (load[0]) vld_q[0] <= in_fire;
            for (int k = 1; k < N; k++) begin
                if (load[k]) vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // NOTE: pure data registers behind a valid bit need no reset; only the valid
    // bits and the visible output register are reset, keeping the datapath cheap.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_q    <= in_a;
            b_q    <= in_b;
            tag0_q <= in_tag;
        end
    end

    generate
        if (PIPE_STAGES > 0) begin : g_rt
            logic [PW-1:0]    rt_prod [PIPE_STAGES];
            logic [TAG_W-1:0] rt_tag  [PIPE_STAGES];

            always_ff @(posedge clk) begin
                if (load[1] && vld_q[0]) begin
                    rt_prod[0] <= mul_res;
                    rt_tag[0]  <= tag0_q;
                end
                for (int k = 1; k < PIPE_STAGES; k++) begin
                    if (load[k+1] && vld_q[k]) begin
                        rt_prod[k] <= rt_prod[k-1];
                        rt_tag[k]  <= rt_tag[k-1];
                    end
                end
            end

            assign so_src_prod = rt_prod[PIPE_STAGES-1];
            assign so_src_tag  = rt_tag[PIPE_STAGES-1];
        end else begin : g_nort
            assign so_src_prod = mul_res;
            assign so_src_tag  = tag0_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            so_prod <= '0;
            so_tag  <= '0;
        end else if (load[N-1] && vld_q[N-2]) begin
            so_prod <= so_src_prod;
            so_tag  <= so_src_tag;
        end
    end

    assign out_valid   = vld_q[N-1];
    assign out_product = so_prod;
    assign out_tag     = so_tag;

`ifdef MULT_PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_done  <= '0;
            cnt_stall <= '0;
        end else begin
            if (out_valid && out_ready)  cnt_done  <= cnt_done + 32'd1;
            if (out_valid && !out_ready) cnt_stall <= cnt_stall + 32'd1;
        end
    end
`else
    // Counters absent: the datapath above is the whole design.
`endif

endmodule
